// File: rtl/tour_pkg.sv
// Shared types and constants for the tour command sequencer and its queue.
package tour_pkg;

  localparam int unsigned CMD_W = 16;

  localparam logic [7:0] MID_RESP_DEF = 8'h5A;
  localparam logic [7:0] ACK_RESP_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_SNT,
    ST_WAIT_RESP,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_MID   = 2'd1,
    ERR_FINAL = 2'd2,
    ERR_TMO   = 2'd3
  } err_t;

endpackage

// File: rtl/tour_cmd_queue.sv
// Command queue: DEPTH entries of {cmd, nresp}, append-only write pointer,
// random read by index. Contents persist until clr or rst drops the count.
module tour_cmd_queue
  import tour_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 22,
  localparam int unsigned IW   = $clog2(DEPTH),
  localparam int unsigned CW   = IW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic [IW-1:0] rd_idx,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count,
  output logic          full
);

  logic [W-1:0] mem [DEPTH];
  logic         push;

  assign full    = (count == CW'(DEPTH));
  assign push    = wr_en && !full && !clr;
  assign rd_data = mem[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= '0;
    else if (clr)  count <= '0;
    else if (push) count <= count + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[count[IW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/tour_cmd_sequencer.sv
// Replays a queue of RemoteComm commands, checking each command's response
// bytes and reporting pass / first error with a per-command idle timeout.
module tour_cmd_sequencer
  import tour_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned RESP_W   = 6,
  parameter int unsigned TMO_W    = 24,
  parameter logic [7:0]  MID_RESP = MID_RESP_DEF,
  parameter logic [7:0]  ACK_RESP = ACK_RESP_DEF,
  localparam int unsigned IW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [15:0]       wr_cmd,
  input  logic [RESP_W-1:0] wr_nresp,
  output logic              full,
  input  logic              start,
  output logic [15:0]       cmd,
  output logic              snd_cmd,
  input  logic              cmd_snt,
  input  logic              resp_rdy,
  input  logic [7:0]        resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        err_code,
  output logic [IW-1:0]     err_idx
);

  localparam int unsigned CW = IW + 1;
  localparam int unsigned QW = CMD_W + RESP_W;
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t            state;
  logic [IW-1:0]     idx;
  logic [RESP_W-1:0] remaining;
  logic [TMO_W-1:0]  tmo;

  logic [QW-1:0]     q_rd_data;
  logic [CW-1:0]     q_count;
  logic [CMD_W-1:0]  entry_cmd;
  logic [RESP_W-1:0] entry_nresp;
  logic              wr_ok;
  logic              is_last;

  logic              resp_final;
  logic              resp_good;
  logic              ev_adv;
  logic              ev_fail;
  err_t              fail_code;
  logic              go_wait;
  logic              tmo_clr;
  logic [RESP_W-1:0] rem_next;

  assign wr_ok       = wr_en && !start && !clr && (state == ST_IDLE || state == ST_DONE);
  assign entry_cmd   = q_rd_data[QW-1:RESP_W];
  assign entry_nresp = q_rd_data[RESP_W-1:0];
  assign is_last     = ({1'b0, idx} == q_count - CW'(1));

  tour_cmd_queue #(
    .DEPTH (DEPTH),
    .W     (QW)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .wr_en   (wr_ok),
    .wr_data ({wr_cmd, wr_nresp}),
    .rd_idx  (idx),
    .rd_data (q_rd_data),
    .count   (q_count),
    .full    (full)
  );

  // A response arriving together with cmd_snt is judged against the entry's
  // full count, since remaining has not been loaded yet.
  assign resp_final = (state == ST_WAIT_SNT) ? (entry_nresp == RESP_W'(1))
                                             : (remaining == RESP_W'(1));
  assign resp_good  = (resp == (resp_final ? ACK_RESP : MID_RESP));

  always_comb begin
    ev_adv    = 1'b0;
    ev_fail   = 1'b0;
    fail_code = ERR_NONE;
    go_wait   = 1'b0;
    tmo_clr   = 1'b0;
    rem_next  = remaining;
    case (state)
      ST_WAIT_SNT: begin
        if (cmd_snt) begin
          tmo_clr = 1'b1;
          if (entry_nresp == '0) begin
            ev_adv = 1'b1;
          end else if (resp_rdy) begin
            if (!resp_good) begin
              ev_fail   = 1'b1;
              fail_code = resp_final ? ERR_FINAL : ERR_MID;
            end else if (resp_final) begin
              ev_adv = 1'b1;
            end else begin
              go_wait  = 1'b1;
              rem_next = entry_nresp - RESP_W'(1);
            end
          end else begin
            go_wait  = 1'b1;
            rem_next = entry_nresp;
          end
        end else if (resp_rdy) begin
          tmo_clr = 1'b1;
        end else if (tmo == TMO_LAST) begin
          ev_fail   = 1'b1;
          fail_code = ERR_TMO;
        end
      end
      ST_WAIT_RESP: begin
        if (resp_rdy) begin
          tmo_clr = 1'b1;
          if (!resp_good) begin
            ev_fail   = 1'b1;
            fail_code = resp_final ? ERR_FINAL : ERR_MID;
          end else if (resp_final) begin
            ev_adv = 1'b1;
          end else begin
            rem_next = remaining - RESP_W'(1);
          end
        end else if (cmd_snt) begin
          tmo_clr = 1'b1;
        end else if (tmo == TMO_LAST) begin
          ev_fail   = 1'b1;
          fail_code = ERR_TMO;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      remaining <= '0;
      tmo       <= '0;
      cmd       <= '0;
      snd_cmd   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_code  <= ERR_NONE;
      err_idx   <= '0;
    end else begin
      snd_cmd <= 1'b0;
      if (clr) begin
        state    <= ST_IDLE;
        busy     <= 1'b0;
        done     <= 1'b0;
        pass     <= 1'b0;
        err_code <= ERR_NONE;
        err_idx  <= '0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              idx      <= '0;
              err_code <= ERR_NONE;
              err_idx  <= '0;
              pass     <= (q_count == '0);
              done     <= (q_count == '0);
              busy     <= (q_count != '0);
              state    <= (q_count == '0) ? ST_DONE : ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            cmd     <= entry_cmd;
            snd_cmd <= 1'b1;
            tmo     <= '0;
            state   <= ST_WAIT_SNT;
          end
          ST_WAIT_SNT, ST_WAIT_RESP: begin
            remaining <= rem_next;
            tmo       <= tmo_clr ? '0 : tmo + TMO_W'(1);
            if (ev_fail) begin
              state    <= ST_DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              pass     <= 1'b0;
              err_code <= fail_code;
              err_idx  <= idx;
            end else if (ev_adv) begin
              if (is_last) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= 1'b1;
              end else begin
                idx   <= idx + IW'(1);
                state <= ST_ISSUE;
              end
            end else if (go_wait) begin
              state <= ST_WAIT_RESP;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Directed scoreboard bench for tour_cmd_sequencer (DEPTH=4, TMO_W=8).
module tb_tour_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst, clr, wr_en, start, cmd_snt, resp_rdy;
  logic [15:0] wr_cmd, cmd;
  logic [5:0]  wr_nresp;
  logic [7:0]  resp;
  logic        full, snd_cmd, busy, done, pass;
  logic [1:0]  err_code, err_idx;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_cmd_q  [$];
  logic [4:0]  exp_done_q [$];
  logic        prev_done = 1'b0;

  always #5 clk = ~clk;

  tour_cmd_sequencer #(
    .DEPTH  (4),
    .RESP_W (6),
    .TMO_W  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .wr_en    (wr_en),
    .wr_cmd   (wr_cmd),
    .wr_nresp (wr_nresp),
    .full     (full),
    .start    (start),
    .cmd      (cmd),
    .snd_cmd  (snd_cmd),
    .cmd_snt  (cmd_snt),
    .resp_rdy (resp_rdy),
    .resp     (resp),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_code (err_code),
    .err_idx  (err_idx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every send pulse and every rising done against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (snd_cmd) begin
        if (exp_cmd_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL snd_cmd_extra actual=%0h required=none", cmd);
        end else begin
          check("snd_cmd_word", {16'h0, cmd}, {16'h0, exp_cmd_q.pop_front()});
        end
      end
      if (done && !prev_done) begin
        if (exp_done_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL done_extra actual=%0h required=none", {pass, err_code, err_idx});
        end else begin
          check("done_status", {27'h0, pass, err_code, err_idx}, {27'h0, exp_done_q.pop_front()});
        end
      end
      prev_done = done;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [15:0] c, input logic [5:0] n);
    wr_en = 1'b1; wr_cmd = c; wr_nresp = n; cyc(); wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1; cyc(); clr = 1'b0;
  endtask

  task automatic wait_snd(input string name);
    int n = 0;
    while (!snd_cmd && n < 50) begin cyc(); n++; end
    check(name, {31'h0, snd_cmd}, 32'h1);
  endtask

  task automatic remote_sent(input logic with_resp, input logic [7:0] b);
    cmd_snt = 1'b1; resp_rdy = with_resp; resp = b; cyc();
    cmd_snt = 1'b0; resp_rdy = 1'b0;
  endtask

  task automatic reply(input logic [7:0] b);
    resp_rdy = 1'b1; resp = b; cyc(); resp_rdy = 1'b0; cyc();
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 400) begin cyc(); n++; end
    check(name, {31'h0, done}, 32'h1);
  endtask

  initial begin
    int n;
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; start = 1'b0; cmd_snt = 1'b0;
    resp_rdy = 1'b0; wr_cmd = '0; wr_nresp = '0; resp = '0;
    cyc(); cyc();
    check("reset_outputs", {8'h0, cmd, snd_cmd, busy, done, pass, err_code, err_idx, full}, 32'h0);
    rst = 1'b0;
    cyc();

    // single command, two responses
    push(16'h6020, 6'd2);
    exp_cmd_q.push_back(16'h6020);
    exp_done_q.push_back({1'b1, 2'd0, 2'd0});
    pulse_start();
    wait_snd("t1_snd");
    check("t1_busy", {31'h0, busy}, 32'h1);
    remote_sent(1'b0, 8'h00);
    reply(8'h5A);
    reply(8'hA5);
    wait_done("t1_done");

    // three entries, nresp 1/0/2; third gets a response together with cmd_snt
    pulse_clr();
    push(16'h1111, 6'd1); push(16'h2222, 6'd0); push(16'h3333, 6'd2);
    exp_cmd_q.push_back(16'h1111); exp_cmd_q.push_back(16'h2222); exp_cmd_q.push_back(16'h3333);
    exp_done_q.push_back({1'b1, 2'd0, 2'd0});
    pulse_start();
    wait_snd("t2_snd0"); remote_sent(1'b0, 8'h00); reply(8'hA5);
    wait_snd("t2_snd1"); remote_sent(1'b0, 8'h00);
    wait_snd("t2_snd2"); remote_sent(1'b1, 8'h5A); reply(8'hA5);
    wait_done("t2_done");

    // bad final byte on entry 1; entry 2 must never go out
    pulse_clr();
    push(16'h4111, 6'd1); push(16'h4222, 6'd2); push(16'h4333, 6'd1);
    exp_cmd_q.push_back(16'h4111); exp_cmd_q.push_back(16'h4222);
    exp_done_q.push_back({1'b0, 2'd2, 2'd1});
    pulse_start();
    wait_snd("t3_snd0"); remote_sent(1'b0, 8'h00); reply(8'hA5);
    wait_snd("t3_snd1"); remote_sent(1'b0, 8'h00); reply(8'h5A); reply(8'h5B);
    wait_done("t3_done");
    check("t3_err", {28'h0, err_code, err_idx}, {28'h0, 2'd2, 2'd1});
    repeat (10) cyc();

    // replay the persisted queue; bad intermediate byte on entry 1
    exp_cmd_q.push_back(16'h4111); exp_cmd_q.push_back(16'h4222);
    exp_done_q.push_back({1'b0, 2'd1, 2'd1});
    pulse_start();
    check("t3b_restart_clears_done", {31'h0, done}, 32'h0);
    wait_snd("t3b_snd0"); remote_sent(1'b1, 8'hA5);
    wait_snd("t3b_snd1"); remote_sent(1'b0, 8'h00); reply(8'h00);
    wait_done("t3b_done");
    repeat (5) cyc();

    // timeout: 255 idle clocks after cmd_snt
    pulse_clr();
    push(16'hABCD, 6'd1);
    exp_cmd_q.push_back(16'hABCD);
    exp_done_q.push_back({1'b0, 2'd3, 2'd0});
    pulse_start();
    wait_snd("t4_snd");
    remote_sent(1'b0, 8'h00);
    n = 0;
    while (!done && n < 400) begin cyc(); n++; end
    check("t4_tmo_latency", n, 32'd255);
    check("t4_err", {30'h0, err_code}, 32'd3);

    // fill, overflow write ignored, replay all four
    pulse_clr();
    push(16'h5001, 6'd0); push(16'h5002, 6'd0); push(16'h5003, 6'd0); push(16'h5004, 6'd0);
    check("t5_full", {31'h0, full}, 32'h1);
    push(16'h9999, 6'd0);
    check("t5_full_after_extra", {31'h0, full}, 32'h1);
    for (int i = 1; i <= 4; i++) exp_cmd_q.push_back(16'h5000 + 16'(i));
    exp_done_q.push_back({1'b1, 2'd0, 2'd0});
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      wait_snd("t5_snd");
      remote_sent(1'b0, 8'h00);
    end
    wait_done("t5_done");
    pulse_clr();
    check("t5_clr_empties", {31'h0, full}, 32'h0);

    // start on empty queue: done with pass on the next clock
    exp_done_q.push_back({1'b1, 2'd0, 2'd0});
    pulse_start();
    check("t5_empty_start", {30'h0, done, pass}, 32'h3);

    // clr mid-run aborts to IDLE
    push(16'h7777, 6'd1);
    exp_cmd_q.push_back(16'h7777);
    pulse_start();
    wait_snd("t6_snd");
    pulse_clr();
    check("t6_clr_abort", {29'h0, busy, done, pass}, 32'h0);
    repeat (5) cyc();
    check("t6_stays_idle", {30'h0, busy, snd_cmd}, 32'h0);

    // asynchronous reset during WAIT_RESP
    push(16'h1234, 6'd2);
    exp_cmd_q.push_back(16'h1234);
    pulse_start();
    wait_snd("t7_snd");
    remote_sent(1'b0, 8'h00);
    reply(8'h5A);
    check("t7_busy_before_rst", {31'h0, busy}, 32'h1);
    #2 rst = 1'b1;
    #1 check("t7_async_reset", {8'h0, cmd, snd_cmd, busy, done, pass, err_code, err_idx, full}, 32'h0);
    cyc();
    check("t7_no_snd", {31'h0, snd_cmd}, 32'h0);
    rst = 1'b0;
    cyc();
    exp_done_q.push_back({1'b1, 2'd0, 2'd0});
    pulse_start();
    check("t7_queue_discarded", {30'h0, done, pass}, 32'h3);

    repeat (5) cyc();
    check("cmd_queue_drained", exp_cmd_q.size(), 32'd0);
    check("done_queue_drained", exp_done_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tour_cmd_sequencer.md
TOUR_CMD_SEQUENCER -- requirements
Module: tour_cmd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8: command queue entries, power of two, 2..64.
REQ-002 SHALL have parameter RESP_W, default 6: width of expected-response count per command.
REQ-003 SHALL have parameter TMO_W, default 24: width of the response timeout counter; timeout fires at 2^TMO_W-1 idle clocks.
REQ-004 SHALL have parameter MID_RESP, default 8'h5A, and ACK_RESP, default 8'hA5.
REQ-005 Ports, clock and reset first:
  clk  in  1  system clock
  rst  in  1  reset; one clock; reset is asynchronous and active-high
  clr  in  1  empty queue, return to IDLE
  wr_en  in  1  push one queue entry
  wr_cmd  in  16  command word to push
  wr_nresp  in  RESP_W  responses expected for that command
  full  out  1  queue holds DEPTH entries
  start  in  1  run queue from entry 0
  cmd  out  16  command to RemoteComm
  snd_cmd  out  1  one-clock send pulse to RemoteComm
  cmd_snt  in  1  RemoteComm finished transmitting
  resp_rdy  in  1  RemoteComm response valid, one clock
  resp  in  8  response byte
  busy  out  1  run in progress
  done  out  1  run finished; held until start or clr
  pass  out  1  run finished with no error; valid when done
  err_code  out  2  0 none, 1 bad intermediate byte, 2 bad final byte, 3 timeout
  err_idx  out  clog2(DEPTH)  index of failing entry

Function
REQ-006 Queue SHALL be written only in IDLE or DONE; wr_en when full, busy, or simultaneous with start SHALL be ignored.
REQ-007 Queue contents SHALL persist across runs; each start SHALL replay entries 0..count-1 in write order; clr SHALL set count to 0.
REQ-008 States SHALL be IDLE, ISSUE, WAIT_SNT, WAIT_RESP, DONE.
REQ-009 IDLE/DONE + start: count=0 -> DONE with pass=1 next clock; else -> ISSUE, busy=1, done=0, pass=0, err_code=0.
REQ-010 ISSUE SHALL drive cmd=entry, assert snd_cmd exactly one clock, -> WAIT_SNT; cmd SHALL hold until the next ISSUE.
REQ-011 WAIT_SNT + cmd_snt: nresp=0 -> next entry (ISSUE) or DONE if last; else -> WAIT_RESP with responses-remaining=nresp.
REQ-012 resp_rdy in WAIT_SNT on the same clock as cmd_snt SHALL be counted as the first response.
REQ-013 WAIT_RESP: each resp_rdy decrements remaining; non-final responses SHALL equal MID_RESP else err_code=1; final SHALL equal ACK_RESP else err_code=2.
REQ-014 Any error SHALL go to DONE the next clock with pass=0, err_idx=current entry; remaining entries SHALL NOT be issued.
REQ-015 Final correct response: advance to ISSUE for next entry the next clock, or DONE with pass=1 if last.
REQ-016 Timeout counter SHALL clear on entering WAIT_SNT/WAIT_RESP and on every resp_rdy or cmd_snt; saturation in WAIT_SNT or WAIT_RESP -> DONE, err_code=3.
REQ-017 resp_rdy or cmd_snt in IDLE/DONE/ISSUE SHALL be ignored.
REQ-018 start while busy SHALL be ignored; clr while busy SHALL abort to IDLE next clock without snd_cmd, done=0, pass=0.
REQ-019 busy SHALL be 1 exactly in ISSUE, WAIT_SNT, WAIT_RESP.

Reset
REQ-020 rst SHALL asynchronously force IDLE, count=0, cmd=0, snd_cmd=0, busy=0, done=0, pass=0, err_code=0, err_idx=0, timeout=0.
REQ-021 rst mid-run SHALL discard queue contents and suppress any pending snd_cmd.

Structure
REQ-022 State enum, err_code encoding, and MID_RESP/ACK_RESP defaults SHALL live in shared package tour_pkg.
REQ-023 Queue storage SHALL be one sub-module, tour_cmd_queue (DEPTH x (16+RESP_W), write pointer, random read by index).

Verification
REQ-024 Push 16'h6020 nresp=2, start; reply 5A, A5 -> one snd_cmd, cmd=6020, done=1, pass=1.
REQ-025 Push 3 entries nresp 1/0/2, correct replies -> three snd_cmd pulses in order, pass=1; second entry advances on cmd_snt alone.
REQ-026 Entry 1 final reply 8'h5B -> err_code=2, err_idx=1, entry 2 never sent.
REQ-027 TMO_W=8, withhold response -> DONE 255 clocks after last event, err_code=3.
REQ-028 Fill DEPTH entries, extra wr_en -> ignored, full=1; start with empty queue -> pass=1 next clock.
REQ-029 Assert rst during WAIT_RESP -> all outputs reset immediately, no snd_cmd; clr mid-run -> IDLE, done=0.
